// File: rtl/rdl_subreg_pkg.sv
// -----------------------------------------------------------------------------
// rdl_subreg_pkg
// Shared types and helpers for the register-access controller.
//   access_state_e : controller FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   idx_width()    : width of a register index for a given register count
// -----------------------------------------------------------------------------
package rdl_subreg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } access_state_e;

    // A single-register block still needs a one-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rdl_subreg_pkg

// File: rtl/rdl_access_decode.sv
// -----------------------------------------------------------------------------
// rdl_access_decode
// Byte address to register-index decoder.
//   addr_i     : byte address of the access
//   idx_o      : register index (addr / bytes-per-register), truncated
//   aligned_o  : address is a multiple of the register width in bytes
//   in_range_o : full (untruncated) index is below NumRegs
// -----------------------------------------------------------------------------
module rdl_access_decode
    import rdl_subreg_pkg::*;
#(
    parameter int NumRegs = 8,
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int IW      = idx_width(NumRegs)
) (
    input  logic [AW-1:0] addr_i,
    output logic [IW-1:0] idx_o,
    output logic          aligned_o,
    output logic          in_range_o
);

    localparam int Bytes = DW / 8;

    logic [AW-1:0] idx_full_s;

    assign idx_full_s = addr_i / AW'(Bytes);
    assign aligned_o  = ((addr_i % AW'(Bytes)) == '0);
    // Range check uses the full index so high address bits cannot alias
    assign in_range_o = (32'(idx_full_s) < 32'(NumRegs));
    assign idx_o      = IW'(idx_full_s);

endmodule : rdl_access_decode

// File: rtl/rdl_access_ctrl.sv
// -----------------------------------------------------------------------------
// rdl_access_ctrl
// Single-outstanding CPU-to-register access controller.
//   req_*  : CPU request channel (valid/ready, write, addr, wdata, wstrb)
//   rsp_*  : CPU response channel (valid/ready, rdata, err)
//   reg_we / reg_re : one-hot write / read strobes, one cycle in ACCESS
//   reg_wd : merged write data (read-modify-write on byte strobes)
//   reg_qs : packed register read-back values, register i at [i*DW +: DW]
// Optional build macro RDL_ACCESS_CTRL_ERR_EN: report misses via rsp_err.
// -----------------------------------------------------------------------------
module rdl_access_ctrl
    import rdl_subreg_pkg::*;
#(
    parameter int NumRegs = 8,
    parameter int DW      = 32,
    parameter int AW      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [DW-1:0]         req_wdata,
    input  logic [DW/8-1:0]       req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic [NumRegs-1:0]    reg_we,
    output logic [NumRegs-1:0]    reg_re,
    output logic [DW-1:0]         reg_wd,
    input  logic [NumRegs*DW-1:0] reg_qs
);

    localparam int IW = idx_width(NumRegs);

    access_state_e   state_q, state_d;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [IW-1:0]   idx_s;
    logic            aligned_s;
    logic            in_range_s;
    logic            hit_s;
    logic [DW-1:0]   qs_sel_s;
    logic [DW-1:0]   mask_s;

    function automatic logic [DW-1:0] expand_strb(input logic [DW/8-1:0] strb);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < DW/8; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    rdl_access_decode #(
        .NumRegs (NumRegs),
        .DW      (DW),
        .AW      (AW),
        .IW      (IW)
    ) u_decode (
        .addr_i     (addr_q),
        .idx_o      (idx_s),
        .aligned_o  (aligned_s),
        .in_range_o (in_range_s)
    );

    assign hit_s    = aligned_s & in_range_s;
    assign qs_sel_s = reg_qs[idx_s*DW +: DW];
    assign mask_s   = expand_strb(wstrb_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request fields at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (state_q == IDLE && req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end else begin
            write_q <= write_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
            wstrb_q <= wstrb_q;
        end
    end

    // Response registers: loaded in ACCESS, held through RESP, cleared on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end else if (state_q == RESP && rsp_ready) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_rdata_q <= rsp_rdata_q;
            rsp_err_q   <= rsp_err_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data/error selection for the access being performed
    always_comb begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (hit_s && !write_q) begin
            rsp_rdata_d = qs_sel_s;
        end else begin
            rsp_rdata_d = '0;
        end
`ifdef RDL_ACCESS_CTRL_ERR_EN
        rsp_err_d = ~hit_s;
`else
        rsp_err_d = 1'b0;
`endif
    end

    // Outputs; strobes are masked by rst so an abandoned access never fires
    always_comb begin
        req_ready = 1'b0;
        reg_we    = '0;
        reg_re    = '0;
        reg_wd    = '0;
        if (state_q == IDLE && !rst) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end
        if (state_q == ACCESS && !rst && hit_s) begin
            if (write_q) begin
                // An all-zero strobe is a successful no-op write
                if (wstrb_q != '0) begin
                    reg_we[idx_s] = 1'b1;
                    reg_wd        = (qs_sel_s & ~mask_s) | (wdata_q & mask_s);
                end else begin
                    reg_wd = '0;
                end
            end else begin
                reg_re[idx_s] = 1'b1;
            end
        end else begin
            reg_wd = '0;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule : rdl_access_ctrl

// File: tb/tb_rdl_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rdl_access_ctrl
// Directed self-checking bench for rdl_access_ctrl (NumRegs=8, DW=32, AW=12).
// Expected responses are queued at request time and compared at handshake.
// -----------------------------------------------------------------------------
module tb_rdl_access_ctrl;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int AW = 12;

`ifdef RDL_ACCESS_CTRL_ERR_EN
    localparam logic MISS_ERR = 1'b1;
`else
    localparam logic MISS_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NR-1:0]     reg_we;
    logic [NR-1:0]     reg_re;
    logic [DW-1:0]     reg_wd;
    logic [NR*DW-1:0]  reg_qs;

    rsp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    rdl_access_ctrl #(.NumRegs(NR), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_wd    (reg_wd),
        .reg_qs    (reg_qs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; starts just after a rising edge, ends just after one.
    task automatic txn(input string name, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb,
                       input logic [NR-1:0] exp_we, input logic [NR-1:0] exp_re,
                       input logic [DW-1:0] exp_wd, input logic [DW-1:0] exp_rdata,
                       input logic exp_err, input int hold);
        rsp_t e;
        rsp_t got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        @(negedge clk);
        check({name, ".req_ready_T"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0;
        @(negedge clk);
        check({name, ".we_T1"}, 64'(reg_we), 64'(exp_we));
        check({name, ".re_T1"}, 64'(reg_re), 64'(exp_re));
        check({name, ".wd_T1"}, 64'(reg_wd), 64'(exp_wd));
        check({name, ".rsp_valid_T1"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check({name, ".we_T2"}, 64'(reg_we), 64'd0);
        check({name, ".re_T2"}, 64'(reg_re), 64'd0);
        check({name, ".wd_T2"}, 64'(reg_wd), 64'd0);
        check({name, ".rsp_valid_T2"}, 64'(rsp_valid), 64'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            check({name, ".hold_rdata"}, 64'(rsp_rdata), 64'(sb_q[0].rdata));
            check({name, ".hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check({name, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check({name, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
            check({name, ".rsp_rdata"}, 64'(rsp_rdata), 64'(got.rdata));
            check({name, ".rsp_err"}, 64'(rsp_err), 64'(got.err));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 12'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        reg_qs    = '0;
        reg_qs[1*DW +: DW] = 32'h11223344;
        reg_qs[3*DW +: DW] = 32'h5A5A0001;
        reg_qs[7*DW +: DW] = 32'h77770007;

        @(negedge clk);
        check("reset.req_ready", 64'(req_ready), 64'd0);
        check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset.rsp_err", 64'(rsp_err), 64'd0);
        check("reset.we_re", 64'({reg_we, reg_re}), 64'd0);
        check("reset.wd", 64'(reg_wd), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset.req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        txn("wr_full",   1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 8'h04, 8'h00, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        txn("wr_merge",  1'b1, 12'h004, 32'hAABBCCDD, 4'h3, 8'h02, 8'h00, 32'h1122CCDD, 32'h0, 1'b0, 0);
        txn("rd_hit",    1'b0, 12'h00C, 32'h0,        4'h0, 8'h00, 8'h08, 32'h0, 32'h5A5A0001, 1'b0, 0);
        txn("rd_oor",    1'b0, 12'h020, 32'h0,        4'h0, 8'h00, 8'h00, 32'h0, 32'h0, MISS_ERR, 0);
        txn("wr_misal",  1'b1, 12'h006, 32'hFFFFFFFF, 4'hF, 8'h00, 8'h00, 32'h0, 32'h0, MISS_ERR, 0);
        txn("wr_nostrb", 1'b1, 12'h01C, 32'h12345678, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 0);
        txn("wr_byte3",  1'b1, 12'h000, 32'hDEADBEEF, 4'h8, 8'h01, 8'h00, 32'hDE000000, 32'h0, 1'b0, 0);
        txn("rd_last_hold", 1'b0, 12'h01C, 32'h0,     4'h0, 8'h00, 8'h80, 32'h0, 32'h77770007, 1'b0, 5);
        // Issued right after the handshake: must be accepted on the next edge
        txn("rd_b2b",    1'b0, 12'h004, 32'h0,        4'h0, 8'h00, 8'h02, 32'h0, 32'h11223344, 1'b0, 0);

        // Reset during the ACCESS cycle abandons the transaction
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h008;
        req_wdata = 32'hCAFEF00D;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("mid_rst.we", 64'(reg_we), 64'd0);
        check("mid_rst.wd", 64'(reg_wd), 64'd0);
        check("mid_rst.req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst.req_ready_after", 64'(req_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("mid_rst.no_rsp", 64'(rsp_valid), 64'd0);
            check("mid_rst.no_strobe", 64'({reg_we, reg_re}), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Controller still works after an abandoned transaction
        txn("rd_after_rst", 1'b0, 12'h00C, 32'h0, 4'h0, 8'h00, 8'h08, 32'h0, 32'h5A5A0001, 1'b0, 0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rdl_access_ctrl
